// File: rtl/dds_if.sv
// DDS control/BRAM-read bundle between the phase controller and its user.
// master: stimulus side + BRAM data; slave: dds_phase_ctrl.
interface dds_if #(
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 14
);
  logic                  start;
  logic                  stop;
  logic                  ftw_load;
  logic [ACC_WIDTH-1:0]  ftw_in;
  logic [ADDR_WIDTH-1:0] poff_in;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] wave_out;
  logic                  wave_valid;
  logic                  wrap;
  logic                  busy;

  modport master (
    output start, stop, ftw_load, ftw_in,
    output poff_in, rom_data,
    input  raddr, wave_out, wave_valid,
    input  wrap, busy
  );

  modport slave (
    input  start, stop, ftw_load, ftw_in,
    input  poff_in, rom_data,
    output raddr, wave_out, wave_valid,
    output wrap, busy
  );
endinterface

// File: rtl/dds_phase_ctrl.sv
// DDS phase accumulator + sine-table read front-end (1-cycle BRAM).
// Ports: clk, rst_n (async low), bus (dds_if.slave: ctrl, raddr, samples).
module dds_phase_ctrl #(
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 14
) (
  input logic clk,
  input logic rst_n,
  dds_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  ftw;
  logic [ACC_WIDTH:0]    acc_sum;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [DATA_WIDTH-1:0] wave_q;
  logic                  valid_q;
  logic                  wrap_q;

  // v*: sample-valid pipe, p*: wrap tag riding alongside it
  logic v0;
  logic v1;
  logic cr;
  logic p0;
  logic p1;
  logic dcnt;

  logic go;
  logic step;

  assign acc_sum = {1'b0, acc} + {1'b0, ftw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    step     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_nx = RUN;
          go       = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nx = DRAIN;
        end else begin
          step = 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw     <= '0;
      acc     <= '0;
      cr      <= 1'b0;
      raddr_q <= '0;
      v0      <= 1'b0;
      v1      <= 1'b0;
      p0      <= 1'b0;
      p1      <= 1'b0;
      wave_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      dcnt    <= 1'b0;
    end else begin
      if (bus.ftw_load) begin
        ftw <= bus.ftw_in;
      end
      if (go) begin
        acc <= '0;
        cr  <= 1'b0;
      end else if (step) begin
        raddr_q <= acc[ACC_WIDTH-1 -: ADDR_WIDTH] + bus.poff_in;
        acc     <= acc_sum[ACC_WIDTH-1:0];
        cr      <= acc_sum[ACC_WIDTH];
      end
      // carry from the previous update marks the address issued now
      v0      <= step;
      p0      <= step & cr;
      v1      <= v0;
      p1      <= p0;
      valid_q <= v1;
      wrap_q  <= v1 & p1;
      if (v1) begin
        wave_q <= bus.rom_data;
      end
      dcnt <= (state == DRAIN) & ~dcnt;
    end
  end

  assign bus.raddr      = raddr_q;
  assign bus.wave_out   = wave_q;
  assign bus.wave_valid = valid_q;
  assign bus.wrap       = wrap_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Directed bench for dds_phase_ctrl with an identity sine-table model.
// table[i] = i, one-cycle registered read.
module tb_dds_phase_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dds_if #(
    .ACC_WIDTH (32),
    .ADDR_WIDTH(10),
    .DATA_WIDTH(14)
  ) bus ();

  dds_phase_ctrl #(
    .ACC_WIDTH (32),
    .ADDR_WIDTH(10),
    .DATA_WIDTH(14)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= {4'b0, bus.raddr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ftw(input logic [31:0] f);
    bus.ftw_in   = f;
    bus.ftw_load = 1'b1;
    tick();
    bus.ftw_load = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic halt();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.wave_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.raddr !== 10'd0 || bus.wave_out !== 14'd0 ||
        bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset: v=%b b=%b a=%h w=%h r=%b want all 0",
               bus.wave_valid, bus.busy, bus.raddr,
               bus.wave_out, bus.wrap);
    end
    #10;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sweep();
    load_ftw(32'h0040_0000);
    bus.poff_in = 10'd0;
    pulse_start();
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++;
      if (bus.wave_valid !== 1'b0 || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL latency e%0d: v=%b b=%b want v=0 b=1",
                 k, bus.wave_valid, bus.busy);
      end
    end
    for (int i = 0; i <= 1025; i++) begin
      logic [13:0] ew;
      logic        er;
      tick();
      ew = 14'(i % 1024);
      er = (i == 1024);
      total++;
      if (bus.wave_valid !== 1'b1 || bus.wave_out !== ew ||
          bus.wrap !== er) begin
        bad++;
        $display("FAIL sweep %0d: v=%b w=%h r=%b want 1 %h %b",
                 i, bus.wave_valid, bus.wave_out, bus.wrap, ew, er);
      end
    end
    halt();
  endtask

  task automatic test_offset();
    load_ftw(32'h0080_0000);
    bus.poff_in = 10'h3FF;
    pulse_start();
    for (int k = 1; k <= 6; k++) begin
      logic [9:0] ea;
      logic [9:0] ew;
      tick();
      ea = 10'(10'h3FF + 2 * (k - 1));
      total++;
      if (bus.raddr !== ea) begin
        bad++;
        $display("FAIL offset addr e%0d: got %h want %h",
                 k, bus.raddr, ea);
      end
      if (k >= 3) begin
        ew = 10'(10'h3FF + 2 * (k - 3));
        total++;
        if (bus.wave_valid !== 1'b1 || bus.wave_out !== {4'b0, ew}) begin
          bad++;
          $display("FAIL offset data e%0d: v=%b w=%h want 1 %h",
                   k, bus.wave_valid, bus.wave_out, ew);
        end
      end
    end
    halt();
  endtask

  task automatic test_ftw_change();
    logic [9:0] exp_a [5:9];
    exp_a[5] = 10'd4;
    exp_a[6] = 10'd5;
    exp_a[7] = 10'd6;
    exp_a[8] = 10'd9;
    exp_a[9] = 10'd12;
    load_ftw(32'h0040_0000);
    bus.poff_in = 10'd0;
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      if (k == 6) begin
        bus.ftw_in   = 32'h00C0_0000;
        bus.ftw_load = 1'b1;
      end
      tick();
      bus.ftw_load = 1'b0;
      if (k >= 5) begin
        total++;
        if (bus.raddr !== exp_a[k]) begin
          bad++;
          $display("FAIL ftw change e%0d: got %0d want %0d",
                   k, bus.raddr, exp_a[k]);
        end
      end
    end
    halt();
  endtask

  task automatic test_stop();
    load_ftw(32'h0040_0000);
    bus.poff_in = 10'd0;
    pulse_start();
    repeat (10) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    total++;
    if (bus.wave_valid !== 1'b1 || bus.wave_out !== 14'd8 ||
        bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL stop s0: v=%b w=%0d b=%b want 1 8 1",
               bus.wave_valid, bus.wave_out, bus.busy);
    end
    bus.start = 1'b1;
    tick();
    total++;
    if (bus.wave_valid !== 1'b1 || bus.wave_out !== 14'd9 ||
        bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL stop s1: v=%b w=%0d b=%b want 1 9 1",
               bus.wave_valid, bus.wave_out, bus.busy);
    end
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.wave_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.wave_out !== 14'd9) begin
      bad++;
      $display("FAIL stop s2: v=%b b=%b w=%0d want 0 0 9",
               bus.wave_valid, bus.busy, bus.wave_out);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (bus.wave_valid !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL stop idle %0d: v=%b b=%b want 0 0",
                 k, bus.wave_valid, bus.busy);
      end
    end
  endtask

  task automatic test_start_stop_together();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (bus.wave_valid !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL start+stop %0d: v=%b b=%b want 0 0",
                 k, bus.wave_valid, bus.busy);
      end
      tick();
    end
  endtask

  task automatic test_ftw_zero();
    load_ftw(32'h0000_0000);
    bus.poff_in = 10'h155;
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      tick();
      total++;
      if (bus.raddr !== 10'h155 || bus.wrap !== 1'b0) begin
        bad++;
        $display("FAIL ftw0 addr e%0d: a=%h r=%b want 155 0",
                 k, bus.raddr, bus.wrap);
      end
      if (k >= 3) begin
        total++;
        if (bus.wave_valid !== 1'b1 || bus.wave_out !== 14'h155) begin
          bad++;
          $display("FAIL ftw0 data e%0d: v=%b w=%h want 1 155",
                   k, bus.wave_valid, bus.wave_out);
        end
      end
    end
    halt();
  endtask

  task automatic test_async_reset();
    load_ftw(32'h0040_0000);
    bus.poff_in = 10'd0;
    pulse_start();
    repeat (8) tick();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.wave_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.raddr !== 10'd0 || bus.wave_out !== 14'd0 ||
        bus.wrap !== 1'b0) begin
      bad++;
      $display("FAIL async reset: v=%b b=%b a=%h w=%h r=%b want 0",
               bus.wave_valid, bus.busy, bus.raddr,
               bus.wave_out, bus.wrap);
    end
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (bus.wave_valid !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL post reset %0d: v=%b b=%b want 0 0",
                 k, bus.wave_valid, bus.busy);
      end
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.ftw_load = 1'b0;
    bus.ftw_in   = '0;
    bus.poff_in  = '0;
    rst_n        = 1'b0;
    test_reset();
    test_sweep();
    test_offset();
    test_ftw_change();
    test_stop();
    test_start_stop_together();
    test_ftw_zero();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
